axi_rd_line_assembler: RTL
==========================

// Module: axi_rd_line_assembler
// PURPOSE
//   Parametrised data-cache refill assembler: packs BEATS AXI read-data beats of BEAT_W
//   bits into one LINE_W-bit cache line. Presents the line on a valid/ready port to the
//   dcache fill logic. Sits between the AXI R channel and the dcache refill write port.
//   Adds over the fixed 2x8 shifter: arbitrary width/depth, indexed beat placement,
//   output handshake with backpressure, length/error flags and optional critical-word-first.
// PARAMETERS
//   BEAT_W   8   width of one AXI read beat in bits (>=1)
//   BEATS    2   beats per cache line; power of two, >=2
//   LINE_W   BEAT_W*BEATS (localparam)   assembled line width
//   CNT_W    $clog2(BEATS) (localparam)  beat index width
// PORTS
//   clk_i          in   1        clock, all state on rising edge
//   rst_i          in   1        synchronous reset, active-high
//   beat_valid_i   in   1        R-channel beat valid
//   beat_ready_o   out  1        R-channel beat ready
//   beat_data_i    in   BEAT_W   R-channel beat data
//   beat_last_i    in   1        R-channel last beat of burst
//   beat_err_i     in   1        R-channel response error (SLVERR/DECERR) on this beat
//   start_idx_i    in   CNT_W    first-beat line index; present only with AXI_RD_CWF_EN
//   line_valid_o   out  1        assembled line available
//   line_ready_i   in   1        consumer accepts line
//   line_data_o    out  LINE_W   assembled line, beat index k at [k*BEAT_W +: BEAT_W]
//   line_err_o     out  1        OR of beat_err_i over all beats of this line
//   line_len_err_o out  1        burst length did not equal BEATS
// BEHAVIOUR
//   - Reset (rst_i=1 at edge): cnt=0, line_valid_o=0, line_data_o=0, line_err_o=0,
//     line_len_err_o=0, start offset=0. beat_ready_o=0 while rst_i=1.
//   - States: FILL (line_valid_o=0) and HOLD (line_valid_o=1).
//   - beat_ready_o = !rst_i && (!line_valid_o || line_ready_i) (comb. ready-through).
//   - Beat handshake = beat_valid_i && beat_ready_o. Per accepted beat:
//     write beat_data_i at index (off+cnt) mod BEATS; OR beat_err_i into err accumulator.
//   - First beat of a line (cnt==0): zero all other line slots; clear err/len accumulators.
//   - Completion: accepted beat with beat_last_i=1 OR cnt==BEATS-1, whichever first.
//     On completion: cnt<=0, line_valid_o<=1 next cycle (latency 1 from final beat).
//     line_len_err_o<=1 if (last && cnt!=BEATS-1) or (cnt==BEATS-1 && !last).
//     Short burst: unwritten slots read as zero. Long burst: excess beats start a new line.
//   - Non-final beat: cnt<=cnt+1; cnt wraps via completion only, never overflows.
//   - HOLD: line_data_o/line_err_o/line_len_err_o stable until line_valid_o && line_ready_i.
//   - Simultaneous line handshake and beat accept: line_valid_o<=0 (or 1 if that beat
//     completes a BEATS==1-style line; n/a since BEATS>=2); beat written as index 0 of
//     the fresh line; old contents overwritten same edge; no beat is lost.
//   - beat_data_i/beat_last_i/beat_err_i ignored when beat_valid_i=0.
//   - Reset mid-line: partial line discarded, next accepted beat is cnt=0.
// CONFIGURATION
//   AXI_RD_CWF_EN defined: critical-word-first wrap bursts. start_idx_i sampled with the
//     cnt==0 beat into off; beats placed at (off+cnt) mod BEATS; off held for rest of line.
//   AXI_RD_CWF_EN undefined: start_idx_i port absent; off constant 0 (linear fill).
// TESTING (BEAT_W=8, BEATS=4 unless noted)
//   1 reset 3 cycles, release -> all outputs 0, beat_ready_o=1 first cycle after release.
//   2 beats 11,22,33,44(last) back-to-back, line_ready_i=1 -> next cycle line_valid_o=1,
//     line_data_o=0x44332211, line_err_o=0, line_len_err_o=0.
//   3 line held with line_ready_i=0 -> beat_ready_o=0, data stable 10 cycles; raise
//     line_ready_i with beat_valid_i=1 data 55 -> same-cycle accept, next line slot0=55.
//   4 short burst AA,BB(last) -> line_data_o=0x0000BBAA, line_len_err_o=1.
//   5 beat_err_i=1 on 3rd beat only -> line_err_o=1; next clean line -> line_err_o=0.
//   6 rst_i pulse after 2 beats, then 4 beats 01..04(last) -> line_data_o=0x04030201.
//   7 AXI_RD_CWF_EN, start_idx_i=2, beats A1,B2,C3,D4(last) -> line_data_o=0xB2A1D4C3.

Source files
------------

// File: rtl/axi_rd_line_assembler.sv
// Packs BEATS read-data beats into one cache line and hands it on through a valid/ready port.
// Define AXI_RD_CWF_EN to enable critical-word-first placement through start_idx_i.
`timescale 1ns/1ps
module axi_rd_line_assembler #(
    parameter int BEAT_W = 8,
    parameter int BEATS  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     beat_valid_i,
    output logic                     beat_ready_o,
    input  logic [BEAT_W-1:0]        beat_data_i,
    input  logic                     beat_last_i,
    input  logic                     beat_err_i,
`ifdef AXI_RD_CWF_EN
    input  logic [$clog2(BEATS)-1:0] start_idx_i,
`endif
    output logic                     line_valid_o,
    input  logic                     line_ready_i,
    output logic [BEAT_W*BEATS-1:0]  line_data_o,
    output logic                     line_err_o,
    output logic                     line_len_err_o
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, off, idx;
    logic              err_acc;
    logic              accept, first, at_end, complete;
    logic [LINE_W-1:0] data_next;

`ifdef AXI_RD_CWF_EN
    logic [CNT_W-1:0] off_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            off_q <= '0;
        else if (accept && first)
            off_q <= start_idx_i;
    end

    // The first beat uses the live start index; later beats reuse the captured one.
    assign off = first ? start_idx_i : off_q;
`else
    assign off = '0;
`endif

    assign line_valid_o = (state == HOLD);
    assign beat_ready_o = !rst_i && (!line_valid_o || line_ready_i);
    assign accept       = beat_valid_i && beat_ready_o;
    assign first        = (cnt == '0);
    assign at_end       = (cnt == LAST_IDX);
    assign complete     = accept && (beat_last_i || at_end);
    assign idx          = off + cnt;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        if (complete)
            state_next = HOLD;
        else if (line_valid_o && line_ready_i)
            state_next = FILL;
    end

    // A new line starts from all-zero so slots a short burst never writes read as zero.
    always_comb begin
        data_next = first ? '0 : line_data_o;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == CNT_W'(k))
                data_next[k*BEAT_W +: BEAT_W] = beat_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= FILL;
        else
            state <= state_next;
    end

    // NOTE: the line register is a plain flop vector, so it is reset along with the control state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt            <= '0;
            err_acc        <= 1'b0;
            line_data_o    <= '0;
            line_err_o     <= 1'b0;
            line_len_err_o <= 1'b0;
        end else if (accept) begin
            line_data_o <= data_next;
            if (complete) begin
                cnt            <= '0;
                err_acc        <= 1'b0;
                line_err_o     <= err_acc || beat_err_i;
                line_len_err_o <= beat_last_i != at_end;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                err_acc <= err_acc || beat_err_i;
            end
        end
    end
endmodule
